// File: rtl/alu_wb.sv
// alu_wb -- ALU write-back stage.
// Buffers register writes from a completed ALU operation in a small FIFO.
// It drains them to the register file with a valid/ready handshake.
// It also keeps the architectural flags, the branch-taken pulse and the overflow counter.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake for one completed ALU operation
//   in_result, in_flags     ALU result and flags ([2] above, [1] equals, [0] overflow)
//   in_func, in_rd          function code and destination register
//   in_wr_en                operation writes a register
//   flush                   synchronous discard of all buffered writes
//   rf_we/rf_addr/rf_wdata  head-of-buffer write request to the register file
//   rf_ready                register file takes the head entry this cycle
//   flags_q                 architectural flags register
//   br_taken                one-cycle pulse when a BRFL condition matched
//   ovf_cnt                 saturating count of accepted operations with overflow
module alu_wb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [2:0]  in_flags,
  input  logic [5:0]  in_func,
  input  logic [4:0]  in_rd,
  input  logic        in_wr_en,
  input  logic        flush,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  input  logic        rf_ready,
  output logic [2:0]  flags_q,
  output logic        br_taken,
  output logic [7:0]  ovf_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [5:0] FUNC_BRFL = 6'b111111;

  // Functions whose flags become architectural: ADD, SUB, CMP and CMPU.
  function automatic logic is_flag_func(input logic [5:0] func);
    logic r;
    case (func)
      6'b100000: r = 1'b1;
      6'b100010: r = 1'b1;
      6'b011000: r = 1'b1;
      6'b011010: r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  logic [36:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [2:0]    flags_d;
  logic          br_taken_q, br_taken_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;
  logic          accept_s, enq_s, deq_s;
  logic [36:0]   head_s;

  assign head_s   = mem_q[rd_ptr_q];
  assign in_ready = (count_q < DEPTH_C);
  assign rf_we    = (count_q != {(PW+1){1'b0}});
  // The head is masked while empty so stale storage never shows on the bus.
  assign rf_addr  = rf_we ? head_s[36:32] : 5'd0;
  assign rf_wdata = rf_we ? head_s[31:0]  : 32'd0;
  assign br_taken = br_taken_q;
  assign ovf_cnt  = ovf_cnt_q;

  // Next-state logic for the buffer occupancy, pointers, flags, branch pulse and counter.
  always_comb begin
    accept_s = in_valid && in_ready;
    // A flush drops the enqueue and the dequeue of the same cycle.
    enq_s    = accept_s && in_wr_en && (in_func != FUNC_BRFL) && (in_rd != 5'd0) && !flush;
    deq_s    = rf_we && rf_ready && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {(PW+1){1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + {{PW{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{PW{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end

    // Flags, branch pulse and overflow count track acceptance, independent of flush.
    if (accept_s && is_flag_func(in_func)) begin
      flags_d = in_flags;
    end else begin
      flags_d = flags_q;
    end
    br_taken_d = accept_s && (in_func == FUNC_BRFL) && in_result[0];
    if (accept_s && in_flags[0] && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Control and status state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {(PW+1){1'b0}};
      flags_q    <= 3'b000;
      br_taken_q <= 1'b0;
      ovf_cnt_q  <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
      br_taken_q <= br_taken_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Write-back buffer storage: {rd, data} per entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 37'd0;
      end
    end else if (enq_s) begin
      mem_q[wr_ptr_q] <= {in_rd, in_result};
    end
  end

endmodule

// File: tb/tb_alu_wb.sv
module tb_alu_wb;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = 32'd0;
  logic [2:0]  in_flags = 3'd0;
  logic [5:0]  in_func = 6'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        in_wr_en = 1'b0;
  logic        flush = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        rf_ready = 1'b1;
  logic [2:0]  flags_q;
  logic        br_taken;
  logic [7:0]  ovf_cnt;

  alu_wb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_func(in_func), .in_rd(in_rd),
    .in_wr_en(in_wr_en), .flush(flush), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .rf_ready(rf_ready), .flags_q(flags_q),
    .br_taken(br_taken), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  pre_cnt = 0;
  logic [2:0] m_flags = 3'b000;
  logic       m_br = 1'b0;
  int         m_ovf = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every register-file write the DUT completes must match the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      pre_cnt = 0;
    end else begin
      pre_cnt = exp_q.size();
      chk("rf_we", rf_we, exp_q.size() != 0);
      if (rf_we && rf_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rf_unexpected: got write rd=%0d expected none", rf_addr);
        end else begin
          e = exp_q.pop_front();
          chk("rf_addr", rf_addr, e.rd);
          chk("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  // Reference model: applies the stage rules to this cycle's inputs.
  always @(negedge clk) begin
    bit acc;
    wr_t e;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      m_flags = 3'b000; m_br = 1'b0; m_ovf = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_addr", rf_addr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_flags", flags_q, 0);
      chk("rst_br", br_taken, 0);
      chk("rst_ovf", ovf_cnt, 0);
    end else begin
      chk("in_ready", in_ready, pre_cnt < DEPTH);
      chk("flags_q", flags_q, m_flags);
      chk("br_taken", br_taken, m_br);
      chk("ovf_cnt", ovf_cnt, m_ovf);
      acc = in_valid && (pre_cnt < DEPTH);
      m_br = acc && (in_func == 6'h3F) && in_result[0];
      if (acc && (in_func == 6'h20 || in_func == 6'h22 || in_func == 6'h18 || in_func == 6'h1A))
        m_flags = in_flags;
      if (acc && in_flags[0] && m_ovf < 255)
        m_ovf++;
      if (flush) begin
        exp_q.delete();
      end else if (acc && in_wr_en && in_func != 6'h3F && in_rd != 5'd0) begin
        e.rd = in_rd;
        e.data = in_result;
        exp_q.push_back(e);
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; in_wr_en = 1'b0; in_func = 6'h01; in_flags = 3'b000;
  endtask

  // Present one operation and hold it until accepted (bounded wait).
  task automatic send(input logic [5:0] f, input logic [31:0] res, input logic [2:0] fl,
                      input logic [4:0] rd, input logic we);
    bit ok;
    in_valid = 1'b1; in_func = f; in_result = res; in_flags = fl; in_rd = rd; in_wr_en = we;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for rd=%0d", rd);
    end
    idle();
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    // ADD right after reset release: accepted on the first edge.
    rst_n = 1'b1;
    rf_ready = 1'b1;
    send(6'h20, 32'd7, 3'b101, 5'd3, 1'b1);
    @(negedge clk);
    chk("add_we", rf_we, 1);
    chk("add_addr", rf_addr, 3);
    chk("add_data", rf_wdata, 7);
    chk("add_flags", flags_q, 3'b101);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: three writes into a two-entry buffer.
    rf_ready = 1'b0;
    send(6'h01, 32'h11, 3'b000, 5'd1, 1'b1);
    send(6'h01, 32'h22, 3'b000, 5'd2, 1'b1);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("held_addr", rf_addr, 1);
    @(posedge clk);
    #1;
    fork
      send(6'h01, 32'h33, 3'b000, 5'd3, 1'b1);
      begin repeat (3) @(posedge clk); #1; rf_ready = 1'b1; end
    join
    repeat (4) @(posedge clk);
    #1;

    // SUB sets flags, BRFL pulses br_taken and writes nothing.
    send(6'h22, 32'd0, 3'b010, 5'd4, 1'b1);
    send(6'h3F, 32'd1, 3'b000, 5'd5, 1'b1);
    @(negedge clk);
    chk("brfl_pulse", br_taken, 1);
    chk("sub_flags", flags_q, 3'b010);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("brfl_pulse_end", br_taken, 0);
    chk("brfl_no_write", rf_we, 0);
    @(posedge clk);
    #1;

    // rd=0 and wr_en=0 are accepted but not buffered.
    send(6'h01, 32'h55, 3'b000, 5'd0, 1'b1);
    send(6'h01, 32'h66, 3'b000, 5'd7, 1'b0);
    @(negedge clk);
    chk("nowrite_we", rf_we, 0);
    @(posedge clk);
    #1;

    // Flush with two buffered entries and a concurrent valid write.
    rf_ready = 1'b0;
    send(6'h01, 32'hA, 3'b000, 5'd8, 1'b1);
    send(6'h01, 32'hB, 3'b000, 5'd9, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_wr_en = 1'b1; in_rd = 5'd10; in_result = 32'hC;
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("flush_we", rf_we, 0);
    chk("flush_flags", flags_q, 3'b010);
    @(posedge clk);
    #1;
    rf_ready = 1'b1;

    // Overflow counter saturation.
    in_valid = 1'b1; in_func = 6'h01; in_flags = 3'b001; in_wr_en = 1'b0;
    repeat (260) @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("ovf_sat", ovf_cnt, 255);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ovf_hold", ovf_cnt, 255);
    @(posedge clk);
    #1;

    // Reset in the middle of a drain.
    rf_ready = 1'b0;
    send(6'h01, 32'hD, 3'b000, 5'd11, 1'b1);
    send(6'h01, 32'hE, 3'b000, 5'd12, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_flags", flags_q, 0);
    chk("mid_rst_ovf", ovf_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rf_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_we", rf_we, 0);
    @(posedge clk);
    #1;

    // Randomised traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(99, 0) < 70);
      in_result = $urandom;
      in_flags  = 3'($urandom_range(7, 0));
      in_rd     = ($urandom_range(9, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      in_wr_en  = ($urandom_range(9, 0) < 8);
      case ($urandom_range(5, 0))
        0: in_func = 6'h20;
        1: in_func = 6'h22;
        2: in_func = 6'h18;
        3: in_func = 6'h1A;
        4: in_func = 6'h3F;
        default: in_func = 6'($urandom_range(63, 0));
      endcase
      flush = ($urandom_range(99, 0) < 3);
      if (flush) in_func = 6'h01;
      rf_ready = ($urandom_range(99, 0) < 60);
      @(posedge clk);
      #1;
    end
    idle();
    rf_ready = 1'b1;
    repeat (2 * DEPTH + 2) @(posedge clk);
    #1;
    @(negedge clk);
    #2;
    chk("final_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_wb.md
ALU_WB -- requirements
Module: alu_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of write-back buffer entries (legal values 2 or 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream ALU has a completed operation this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept the operation this cycle.
REQ-006 SHALL have port in_result  input  32  signed ALU result.
REQ-007 SHALL have port in_flags  input  3  ALU flags: [2] above, [1] equals, [0] overflow.
REQ-008 SHALL have port in_func  input  6  ALU function code of the operation.
REQ-009 SHALL have port in_rd  input  5  destination register index.
REQ-010 SHALL have port in_wr_en  input  1  operation writes a register.
REQ-011 SHALL have port flush  input  1  synchronous discard of all buffered writes.
REQ-012 SHALL have port rf_we  output  1  register-file write request, head entry valid.
REQ-013 SHALL have port rf_addr  output  5  head entry register index.
REQ-014 SHALL have port rf_wdata  output  32  head entry data.
REQ-015 SHALL have port rf_ready  input  1  register file accepts the write this cycle.
REQ-016 SHALL have port flags_q  output  3  architectural flags register, fed back to the ALU's flags_in.
REQ-017 SHALL have port br_taken  output  1  one-cycle pulse: BRFL condition matched.
REQ-018 SHALL have port ovf_cnt  output  8  saturating count of accepted operations with overflow flag set.

Function
REQ-019 Accept: an operation SHALL be accepted on a cycle where in_valid=1 and in_ready=1.
REQ-020 in_ready SHALL be 1 iff buffered entry count < DEPTH; count is registered; no same-cycle pass-through when full.
REQ-021 An accepted operation SHALL be enqueued iff in_wr_en=1, in_func != 6'b111111 and in_rd != 0; otherwise nothing is enqueued.
REQ-022 Enqueued entries SHALL be drained in FIFO order; rf_we=1 iff count > 0; rf_addr/rf_wdata SHALL show the head entry.
REQ-023 Dequeue SHALL occur on a cycle where rf_we=1 and rf_ready=1; rf_we SHALL stay asserted with stable rf_addr/rf_wdata while rf_ready=0.
REQ-024 Latency: an entry enqueued in cycle N SHALL appear on rf_we/rf_addr/rf_wdata no earlier than cycle N+1 (N+1 when buffer was empty).
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-026 flags_q SHALL load in_flags on accept when in_func is 6'b100000, 6'b100010, 6'b011000 or 6'b011010; other functions SHALL leave flags_q unchanged.
REQ-027 flags_q SHALL update on acceptance, not on drain, and SHALL be visible the cycle after acceptance.
REQ-028 br_taken SHALL be 1 in cycle N+1 iff an operation with in_func=6'b111111 and in_result[0]=1 was accepted in cycle N; else 0.
REQ-029 ovf_cnt SHALL increment by 1 on each accepted operation with in_flags[0]=1, saturating at 255.
REQ-030 flush=1 SHALL set count to 0 and drop any same-cycle enqueue and dequeue; flags_q, ovf_cnt and br_taken SHALL be unaffected.
REQ-031 in_valid=1 with in_ready=0 SHALL cause no state change.

Reset
REQ-032 While rst_n=0, buffer count, read/write pointers SHALL be 0, and outputs SHALL be: in_ready=1, rf_we=0, rf_addr=0, rf_wdata=0, flags_q=3'b000, br_taken=0, ovf_cnt=0.
REQ-033 Reset asserted mid-operation SHALL immediately discard all buffered entries; no write SHALL be issued for them after release.
REQ-034 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 ADD (func 100000) result 32'd7, rd=3, wr_en=1, rf_ready=1 -> next cycle rf_we=1, rf_addr=3, rf_wdata=7; flags_q=in_flags.
REQ-036 rf_ready=0, three writes presented (rd 1,2,3), DEPTH=2 -> in_ready=0 after second accept; third held; on rf_ready=1 drains 1,2 then 3 in order.
REQ-037 SUB with in_flags=3'b010, then BRFL with in_result=1 -> flags_q=3'b010, br_taken pulses one cycle, no rf write for BRFL.
REQ-038 Write with rd=0 and write with wr_en=0 -> accepted, rf_we stays 0.
REQ-039 260 accepts with in_flags[0]=1 -> ovf_cnt=255 and holds.
REQ-040 Two entries buffered, flush=1 with concurrent valid write -> count 0, rf_we=0 next cycle, flags_q unchanged; rst_n low mid-drain -> all outputs at reset values immediately.
